wb_issue_scheduler: RTL and testbench

//  Issue/write-back controller in front of the 16x16 register file of the 3-stage pipeline.

---
 rtl/wb_issue_scheduler.sv | 123 ++++++++++++
 tb/tb_wb_issue_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_issue_scheduler.sv
// Issue/write-back controller: per-register pending-write scoreboard, RAW/WAW issue gating,
// and round-robin ALU/MEM arbitration onto the single RF write port. Optional: WB_BYPASS_EN.

module wbPendCounter #(
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            underflow
);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // An issue and a retire on the same register cancel out, including at zero.
  assign underflow = dec && !inc && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt <= '0;
    else if (inc && !dec && cnt != CNT_MAX)    cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)         cnt <= cnt - 1'b1;
  end
endmodule

module wb_issue_scheduler #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 16,
  parameter int CNTW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_dest,
  input  logic [AW-1:0] issue_src1,
  input  logic [AW-1:0] issue_src2,
  output logic          issue_ready,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dest,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_dest,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          sb_err
);
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  typedef enum logic {ARB_ALU, ARB_MEM} arb_e;
  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } wbReq_t;

  arb_e                      rrPtr;
  wbReq_t                    grantReq;
  logic                      grantAlu, grantMem, anyGrant;
  logic                      src1Busy, src2Busy, destFull, issueAccept;
  logic [NREG-1:0][CNTW-1:0] pend;
  logic [NREG-1:0]           pendInc, pendDec, pendUnderflow;

  // Arbiter: a lone requester always wins; on contention rrPtr decides.
  always_comb begin
    grantAlu = alu_valid && (!mem_valid || rrPtr == ARB_ALU);
    grantMem = mem_valid && (!alu_valid || rrPtr == ARB_MEM);
    anyGrant = grantAlu || grantMem;
    grantReq = grantMem ? '{dest: mem_dest, data: mem_data}
                        : '{dest: alu_dest, data: alu_data};
  end

  assign alu_ready = grantAlu;
  assign mem_ready = grantMem;

  always_comb begin
    src1Busy = (pend[issue_src1] != '0);
    src2Busy = (pend[issue_src2] != '0);
`ifdef WB_BYPASS_EN
    // The last outstanding write landing this cycle is visible through RF write-through.
    if (anyGrant && pend[issue_src1] == CNT_ONE && grantReq.dest == issue_src1) src1Busy = 1'b0;
    if (anyGrant && pend[issue_src2] == CNT_ONE && grantReq.dest == issue_src2) src2Busy = 1'b0;
`endif
    destFull    = (pend[issue_dest] == CNT_MAX);
    issue_ready = !src1Busy && !src2Busy && !destFull;
    issueAccept = issue_valid && issue_ready;
  end

  for (genvar g = 0; g < NREG; g++) begin : gPend
    assign pendInc[g] = issueAccept && (issue_dest == AW'(g));
    assign pendDec[g] = anyGrant && (grantReq.dest == AW'(g));
    wbPendCounter #(.CNTW(CNTW)) uCnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (pendInc[g]),
      .dec      (pendDec[g]),
      .cnt      (pend[g]),
      .underflow(pendUnderflow[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrPtr    <= ARB_ALU;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      sb_err   <= 1'b0;
    end else begin
      if (alu_valid && mem_valid) rrPtr <= grantAlu ? ARB_MEM : ARB_ALU;
      rf_we <= anyGrant;
      if (anyGrant) begin
        rf_waddr <= grantReq.dest;
        rf_wdata <= grantReq.data;
      end
      if (|pendUnderflow) sb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_issue_scheduler.sv
// Table-driven bench for wb_issue_scheduler with a write-back scoreboard queue.
module tb_wb_issue_scheduler;
  localparam int AW = 4;
  localparam int DW = 16;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic issue_valid = 0, alu_valid = 0, mem_valid = 0;
  logic [AW-1:0] issue_dest = 0, issue_src1 = 0, issue_src2 = 0, alu_dest = 0, mem_dest = 0;
  logic [DW-1:0] alu_data = 0, mem_data = 0;
  logic issue_ready, alu_ready, mem_ready, rf_we, sb_err;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  wb_issue_scheduler dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_src1(issue_src1),
    .issue_src2(issue_src2), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [AW-1:0] d, s1, s2;
    logic          av;
    logic [AW-1:0] ad;
    logic [DW-1:0] adat;
    logic          mv;
    logic [AW-1:0] md;
    logic [DW-1:0] mdat;
    logic          eI, eA, eM;
  } vec_t;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wb_t;

  vec_t vecs[$];
  wb_t  sbq[$];
  int   total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic iv, int d, int s1, int s2,
                              logic av, int ad, int adat, logic mv, int md, int mdat,
                              logic eI, logic eA, logic eM);
    vec_t v;
    v.iv = iv; v.d = AW'(d); v.s1 = AW'(s1); v.s2 = AW'(s2);
    v.av = av; v.ad = AW'(ad); v.adat = DW'(adat);
    v.mv = mv; v.md = AW'(md); v.mdat = DW'(mdat);
    v.eI = eI; v.eA = eA; v.eM = eM;
    return v;
  endfunction

  // Called just after a posedge; returns just after the following posedge.
  task automatic step(input vec_t v, input int idx);
    wb_t e, got;
    issue_valid = v.iv; issue_dest = v.d; issue_src1 = v.s1; issue_src2 = v.s2;
    alu_valid = v.av; alu_dest = v.ad; alu_data = v.adat;
    mem_valid = v.mv; mem_dest = v.md; mem_data = v.mdat;
    @(negedge clk);
    chk($sformatf("v%0d issue_ready", idx), 32'(issue_ready), 32'(v.eI));
    chk($sformatf("v%0d alu_ready", idx), 32'(alu_ready), 32'(v.eA));
    chk($sformatf("v%0d mem_ready", idx), 32'(mem_ready), 32'(v.eM));
    if (v.eA) begin e.a = v.ad; e.d = v.adat; sbq.push_back(e); end
    else if (v.eM) begin e.a = v.md; e.d = v.mdat; sbq.push_back(e); end
    @(posedge clk); #1;
    chk($sformatf("v%0d rf_we", idx), 32'(rf_we), 32'(sbq.size() != 0));
    if (sbq.size() != 0) begin
      got = sbq.pop_front();
      chk($sformatf("v%0d rf_waddr", idx), 32'(rf_waddr), 32'(got.a));
      chk($sformatf("v%0d rf_wdata", idx), 32'(rf_wdata), 32'(got.d));
    end
  endtask

  task automatic idle();
    issue_valid = 0; alu_valid = 0; mem_valid = 0;
    issue_dest = 0; issue_src1 = 0; issue_src2 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    sbq.delete();
    #1;
    chk("rst rf_we", 32'(rf_we), 0);
    chk("rst sb_err", 32'(sb_err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  int n1, n2, n3, n4;

  initial begin
    // Test 1: RAW on R3 until its retire (bypass makes the retire cycle ready).
    vecs.push_back(mk(1, 3, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 4, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4, 3, 1, 1, 3, 'h1111, 0, 0, 0, BYP, 1, 0));
    vecs.push_back(mk(1, 4, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    n1 = vecs.size();
    // Test 2: fill R1/R2 twice each, then contended arbitration alternates.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'hA000, 1, 2, 'hB000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'hA001, 1, 2, 'hB000, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'hA001, 1, 2, 'hB001, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'hA002, 1, 2, 'hB001, 1, 0, 1));
    // Test 3: R5 saturates at 3, one retire reopens it.
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 1, 5, 'hC5C5, 0, 0, 1));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Test 4: same-cycle issue and retire of R7 leaves pend[7] at 1.
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 7, 0, 0, 1, 7, 'h7777, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8, 7, 0, 1, 7, 'h7778, 0, 0, 0, BYP, 1, 0));
    vecs.push_back(mk(0, 8, 7, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    n2 = vecs.size();
    // Test 5: retire R9 with an empty counter.
    vecs.push_back(mk(0, 0, 9, 0, 1, 9, 'h9999, 0, 0, 0, 1, 1, 0));
    n3 = vecs.size();
    vecs.push_back(mk(0, 0, 9, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 'h9A9A, 1, 0, 1));
    n4 = vecs.size();

    do_reset();
    chk("rst issue_ready", 32'(issue_ready), 1);
    chk("rst rf_waddr", 32'(rf_waddr), 0);
    chk("rst rf_wdata", 32'(rf_wdata), 0);
    for (int i = 0; i < n1; i++) step(vecs[i], i);

    do_reset();
    for (int i = n1; i < n2; i++) step(vecs[i], i);
    chk("no spurious sb_err", 32'(sb_err), 0);

    for (int i = n2; i < n3; i++) step(vecs[i], i);
    chk("sb_err set", 32'(sb_err), 1);
    for (int i = n3; i < n4; i++) step(vecs[i], i);
    chk("sb_err sticky", 32'(sb_err), 1);

    // Reset asserted mid-grant: write port and error flag drop at once.
    alu_valid = 1; alu_dest = 4'd10; alu_data = 16'hDEAD;
    #3;
    chk("pre-reset rf_we", 32'(rf_we), 1);
    rst = 1'b0;
    #1;
    chk("async rf_we", 32'(rf_we), 0);
    chk("async sb_err", 32'(sb_err), 0);
    chk("async rf_waddr", 32'(rf_waddr), 0);
    idle();
    sbq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post-reset rf_we", 32'(rf_we), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
